// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes ADD/SUB/NOP/illegal, reads operands with writeback bypass,
// tracks pending destinations in a scoreboard and holds one issued instruction toward execute.
module decode_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  output logic            if_ready,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [1:0]      ex_op,
  output logic [AW-1:0]   ex_rd,
  output logic [XLEN-1:0] ex_opa,
  output logic [XLEN-1:0] ex_opb,
  output logic [CW-1:0]   illegal_cnt
);

  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  logic [1:0]      w_op;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [AW-1:0]   w_rd;
  logic            w_is_alu;
  logic            w_byp1;
  logic            w_byp2;
  logic            w_byp_rd;
  logic            w_hazard;
  logic            w_slot_free;
  logic            w_issue;
  logic            w_accept_illegal;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic            w_unused;

  logic [NREG-1:0] r_pending;
  logic            r_ex_valid;
  logic [1:0]      r_ex_op;
  logic [AW-1:0]   r_ex_rd;
  logic [XLEN-1:0] r_ex_opa;
  logic [XLEN-1:0] r_ex_opb;
  logic [CW-1:0]   r_illegal_cnt;

  assign w_op     = if_inst[31:30];
  assign w_rs1    = if_inst[29:25];
  assign w_rs2    = if_inst[24:20];
  assign w_rd     = if_inst[19:15];
  assign w_unused = ^if_inst[14:0];

  assign rf_raddr1 = w_rs1;
  assign rf_raddr2 = w_rs2;

  assign w_is_alu = (w_op[1] == 1'b0);

  // Register 0 is hardwired to zero, so it never bypasses and never hazards.
  assign w_byp1   = wb_valid && (wb_rd == w_rs1) && (w_rs1 != '0);
  assign w_byp2   = wb_valid && (wb_rd == w_rs2) && (w_rs2 != '0);
  assign w_byp_rd = wb_valid && (wb_rd == w_rd);

  always_comb begin
    w_opa = rf_rdata1;
    w_opb = rf_rdata2;
    if (w_rs1 == '0)  w_opa = '0;
    else if (w_byp1)  w_opa = wb_data;
    if (w_rs2 == '0)  w_opb = '0;
    else if (w_byp2)  w_opb = wb_data;
  end

  assign w_hazard = w_is_alu && (
                      ((w_rs1 != '0) && r_pending[w_rs1] && !w_byp1) ||
                      ((w_rs2 != '0) && r_pending[w_rs2] && !w_byp2) ||
                      ((w_rd  != '0) && r_pending[w_rd]  && !w_byp_rd));

  assign w_slot_free = !r_ex_valid || ex_ready;

  // NOPs and illegal words are always swallowed; only ALU ops wait on the slot or hazards.
  assign if_ready = w_is_alu ? (w_slot_free && !w_hazard) : 1'b1;

  assign w_issue          = if_valid && if_ready && w_is_alu;
  assign w_accept_illegal = if_valid && (w_op == OP_ILLEGAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_opa   <= '0;
      r_ex_opb   <= '0;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_op    <= w_op;
      r_ex_rd    <= w_rd;
      r_ex_opa   <= w_opa;
      r_ex_opb   <= w_opb;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Set is written after clear so a same-cycle set on the same register wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      if (wb_valid)
        r_pending[wb_rd] <= 1'b0;
      if (w_issue && (w_rd != '0))
        r_pending[w_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_illegal_cnt <= '0;
    else if (w_accept_illegal && (r_illegal_cnt != '1))
      r_illegal_cnt <= r_illegal_cnt + CW'(1);
  end

  assign ex_valid    = r_ex_valid;
  assign ex_op       = r_ex_op;
  assign ex_rd       = r_ex_rd;
  assign ex_opa      = r_ex_opa;
  assign ex_opb      = r_ex_opb;
  assign illegal_cnt = r_illegal_cnt;

endmodule
